// File: rtl/stream_source_fifo.sv
// stream_source_fifo: first-word-fall-through FIFO that feeds a valid/ready
// stream. The write side has no backpressure, so writes that arrive while the
// FIFO is full and nothing drains are dropped.
// Optional feature: define STREAM_FIFO_DROP_CNT_EN to add a saturating 16-bit
// drop_count output.
module stream_source_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     flush,
  output logic                     stream_in_valid,
  output logic [WIDTH-1:0]         stream_in_data,
  input  logic                     stream_in_ready,
  output logic [$clog2(DEPTH):0]   level,
`ifdef STREAM_FIFO_DROP_CNT_EN
  output logic [15:0]              drop_count,
`endif
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      level_q;
  logic [AW:0]      level_next;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_next;
  logic             transfer;
  logic             accept;
  logic             drop;

  assign stream_in_valid = (level_q != '0);
  assign full            = (level_q == FULL_LEVEL);
  assign level           = level_q;
  assign stream_in_data  = data_q;

  // Qualify the handshake and the write; flush overrides both sides.
  always_comb begin
    transfer = stream_in_valid && stream_in_ready && !flush;
    accept   = wr_en && !flush && (!full || transfer);
    drop     = wr_en && !flush && full && !transfer;
  end

  // Next occupancy, next head pointer and the word that will be at the head.
  // A freshly written word becomes the head when it lands exactly where the
  // read pointer ends up, i.e. the FIFO was empty or held only the word
  // being popped this edge.
  always_comb begin
    level_next = level_q;
    rd_next    = rd_ptr;
    data_next  = data_q;
    if (flush) begin
      level_next = '0;
    end else begin
      if (transfer) begin
        rd_next = rd_ptr + 1'b1;
      end
      if (accept && !transfer) begin
        level_next = level_q + ONE_LEVEL;
      end else if (transfer && !accept) begin
        level_next = level_q - ONE_LEVEL;
      end
      if (level_next != '0) begin
        if (accept && (wr_ptr == rd_next)) begin
          data_next = wr_data;
        end else begin
          data_next = mem[rd_next];
        end
      end
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      data_q  <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_next;
      level_q <= level_next;
      data_q  <= data_next;
    end
  end

`ifdef STREAM_FIFO_DROP_CNT_EN
  // Count dropped writes, saturating; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_stream_source_fifo.sv
// tb_stream_source_fifo: directed scenarios plus a long randomized run, all
// checked against a queue-based reference model of the FIFO.
module tb_stream_source_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             flush;
  logic             stream_in_valid;
  logic [WIDTH-1:0] stream_in_data;
  logic             stream_in_ready;
  logic [2:0]       level;
  logic             full;
`ifdef STREAM_FIFO_DROP_CNT_EN
  logic [15:0]      drop_count;
`endif

  stream_source_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .flush           (flush),
    .stream_in_valid (stream_in_valid),
    .stream_in_data  (stream_in_data),
    .stream_in_ready (stream_in_ready),
    .level           (level),
`ifdef STREAM_FIFO_DROP_CNT_EN
    .drop_count      (drop_count),
`endif
    .full            (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] modelHead;
  int               modelDrops;

  int checks;
  int errors;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".valid"}, 32'(stream_in_valid), 32'(modelQ.size() > 0));
    checkOutput({tag, ".level"}, 32'(level), 32'(modelQ.size()));
    checkOutput({tag, ".full"},  32'(full), 32'(modelQ.size() == DEPTH));
    checkOutput({tag, ".data"},  32'(stream_in_data), 32'(modelHead));
`ifdef STREAM_FIFO_DROP_CNT_EN
    checkOutput({tag, ".drops"}, 32'(drop_count), 32'(modelDrops));
`endif
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelHead  = '0;
    modelDrops = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO's rules, clock
  // the DUT and check all outputs shortly after the edge.
  task automatic applyStimulus(input logic wr, input logic [WIDTH-1:0] data,
                               input logic rdy, input logic fl,
                               input string tag);
    bit wasFull;
    bit xfer;
    wr_en           = wr;
    wr_data         = data;
    stream_in_ready = rdy;
    flush           = fl;
    if (reset_n) begin
      if (fl) begin
        modelQ.delete();
      end else begin
        wasFull = (modelQ.size() == DEPTH);
        xfer    = (modelQ.size() > 0) && rdy;
        if (xfer) void'(modelQ.pop_front());
        if (wr) begin
          if (!wasFull || xfer) modelQ.push_back(data);
          else if (modelDrops < 16'hFFFF) modelDrops++;
        end
      end
      if (modelQ.size() > 0) modelHead = modelQ[0];
    end
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] nextByte;
    int               writes;
    logic             w;
    logic             r;

    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    flush = 1'b0;
    stream_in_ready = 1'b0;
    modelReset();

    // Reset held, with a write strobe that must be ignored.
    #2;
    checkState("reset");
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, "reset_wr");
    wr_en = 1'b0;
    reset_n = 1'b1;

    // Three writes drained immediately.
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, "seq_11");
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, "seq_22");
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, "seq_33");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "seq_empty");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "seq_hold");

    // Fill past full with ready low, then drain.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, "fill_A");
    checkOutput("fill_A.level4", 32'(level), 32'd4);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain_A");

    // Write while full and draining in the same edge.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, "fill_B");
    applyStimulus(1'b1, 8'hB4, 1'b1, 1'b0, "full_xfer_B4");
    checkOutput("full_xfer.level4", 32'(level), 32'd4);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain_B");
    checkOutput("drain_B.last", 32'(stream_in_data), 32'hB4);

    // Randomized traffic: 1000 incrementing bytes, ready duty above write rate.
    nextByte = 8'hF0;
    writes = 0;
    while (writes < 1000) begin
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(w, w ? nextByte : 8'h00, r, 1'b0, "rand");
      if (w) begin
        nextByte = nextByte + 8'd1;
        writes++;
      end
    end
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "rand_drain");

    // Flush at level 3 overrides a simultaneous write and transfer.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, "fill_C");
    applyStimulus(1'b1, 8'hC9, 1'b1, 1'b1, "flush");
    checkOutput("flush.level0", 32'(level), 32'd0);
    applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0, "post_flush_wr");

    // Asynchronous reset in the middle of a cycle at level 2.
    applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0, "fill_D");
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async.valid", 32'(stream_in_valid), 32'd0);
    checkOutput("async.level", 32'(level), 32'd0);
    checkOutput("async.full",  32'(full), 32'd0);
    checkOutput("async.data",  32'(stream_in_data), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'hE0, 1'b1, 1'b0, "async_hold_wr");
    wr_en = 1'b0;
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0, "after_reset_wr");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "after_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_source_fifo.md
STREAM_SOURCE_FIFO -- requirements
Module: stream_source_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (power of two, >= 2).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  write strobe; no backpressure on this side.
REQ-006 SHALL have port wr_data  input  WIDTH  write data, sampled when wr_en=1.
REQ-007 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-008 SHALL have port stream_in_valid  output  1  downstream stream valid.
REQ-009 SHALL have port stream_in_data  output  WIDTH  downstream stream data.
REQ-010 SHALL have port stream_in_ready  input  1  downstream ready.
REQ-011 SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port full  output  1  level == DEPTH.

Function
REQ-013 SHALL be first-word-fall-through: stream_in_data always equals the oldest entry when stream_in_valid=1.
REQ-014 SHALL assert stream_in_valid iff level > 0.
REQ-015 SHALL pop one entry on each rising edge where stream_in_valid=1 and stream_in_ready=1 (transfer).
REQ-016 SHALL hold stream_in_data stable while stream_in_valid=1 and stream_in_ready=0.
REQ-017 SHALL accept a write on a rising edge where wr_en=1 and (full=0 or a transfer occurs that edge).
REQ-018 SHALL drop a write when wr_en=1, full=1 and no transfer occurs; stored contents and level unchanged.
REQ-019 SHALL make write-to-valid latency one cycle: word written at edge N is visible on stream_in_* after edge N.
REQ-020 SHALL update level as level + accepted_write - transfer, never exceeding DEPTH or going below 0.
REQ-021 SHALL, on simultaneous write and transfer at level 0 < L <= DEPTH, keep level at L and preserve order.
REQ-022 SHALL wrap read and write pointers modulo DEPTH without gap or duplication.
REQ-023 SHALL, when flush=1 at an edge, set level to 0 and ignore wr_en and stream_in_ready that edge (no write, no transfer, no drop).
REQ-024 SHALL keep stream_in_data at its last value when empty (content don't-care, but no X after first write).

Reset
REQ-025 SHALL, while reset_n=0, force level=0, full=0, stream_in_valid=0, pointers=0, independent of clk.
REQ-026 SHALL discard all entries on reset asserted mid-operation, including a write coincident with deassertion edge.
REQ-027 SHALL leave storage array contents unreset; stream_in_data SHALL reset to 0.

Configuration
REQ-028 SHALL, with macro STREAM_FIFO_DROP_CNT_EN defined, add output drop_count (16 bits) incremented by 1 on each dropped write per REQ-018, saturating at 0xFFFF, cleared only by reset_n.
REQ-029 SHALL, without STREAM_FIFO_DROP_CNT_EN, omit the drop_count port and counter; drops are silent and all other behaviour identical.

Verification (DEPTH=4, WIDTH=8)
REQ-030 SHALL cover: reset, write 0x11,0x22,0x33 with stream_in_ready=1 -> stream_in_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after its write, level returns to 0.
REQ-031 SHALL cover: ready=0, write 0xA0..0xA5 -> full=1 after 4th write, level=4, 0xA4/0xA5 dropped, drop_count=2 (macro on); then ready=1 -> 0xA0..0xA3 out in order.
REQ-032 SHALL cover: full with ready=1 and wr_en=1 same edge, 0xB4 written -> level stays 4, no drop, 0xB4 emerges after the 4 prior entries.
REQ-033 SHALL cover: ready toggled randomly 1000 writes of incrementing byte (wrap 0xFF->0x00) with ready duty >= write rate -> output sequence equals input, data stable during every valid&!ready cycle.
REQ-034 SHALL cover: level=3, flush=1 with wr_en=1 and ready=1 -> next cycle level=0, stream_in_valid=0, drop_count unchanged.
REQ-035 SHALL cover: reset_n pulsed low mid-cycle at level=2 -> stream_in_valid=0 and level=0 immediately, before next clk edge.
